// File: rtl/keypad_pkg.sv
// Shared types, constants and helpers for the 4x4 keypad scanner.
// Build option: define KEYPAD_REPEAT_EN to enable auto-repeat in keypad_scan_debounce.
package keypad_pkg;

  typedef enum logic [1:0] {
    StScan,
    StDebounce,
    StHeld,
    StRelease
  } key_state_e;

  localparam int unsigned DefDebounceCycles = 20;
  localparam int unsigned DefScanDwell      = 3;
  localparam int unsigned DefRepeatDelay    = 240;
  localparam int unsigned DefRepeatRate     = 48;

  // Indexed by {row, col}; entry 0 is row 0 / col 0.
  localparam logic [15:0][3:0] KeyMap = {
    4'hD, 4'hF, 4'h0, 4'hE,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  // Index of the lowest-numbered row pulled low (rows are active-low).
  function automatic logic [1:0] lowest_low(input logic [3:0] r);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!r[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // Index of the single driven (low) column.
  function automatic logic [1:0] col_index(input logic [3:0] c);
    logic [1:0] idx;
    case (c)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Step the active-low column drive to the next column.
  function automatic logic [3:0] rotate_cols(input logic [3:0] c);
    return {c[2:0], c[3]};
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for asynchronous active-low inputs; resets to all ones (idle).
module keypad_sync #(
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  // Two-stage capture; output lags the input by two clocks.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scan_debounce.sv
// 4x4 keypad column scanner with press/release debounce and one-cycle key pulse.
// Build option: KEYPAD_REPEAT_EN adds auto-repeat pulses while a key is held.
module keypad_scan_debounce
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
  parameter int unsigned SCAN_DWELL      = DefScanDwell
`ifdef KEYPAD_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY    = DefRepeatDelay,
  parameter int unsigned REPEAT_RATE     = DefRepeatRate
`endif
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] keyCode,
  output logic       keyValid,
  output logic       keyPressed
);

  localparam int unsigned CntW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned DwellW = $clog2(SCAN_DWELL + 1);

  localparam logic [CntW-1:0]   CntMax    = CntW'(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0]   CntLast   = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DwellW-1:0] DwellLast = DwellW'(SCAN_DWELL - 1);

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RptW   = $clog2(RptMax + 1);

  localparam logic [RptW-1:0] RptDelayLast = RptW'(REPEAT_DELAY - 1);
  localparam logic [RptW-1:0] RptRateLast  = RptW'(REPEAT_RATE - 1);

  logic [RptW-1:0] rpt_cnt_q;
  logic            rpt_first_q;
`endif

  key_state_e        state_q;
  logic [3:0]        cols_q;
  logic [DwellW-1:0] dwell_q;
  logic [CntW-1:0]   cnt_q;
  logic [1:0]        row_q;
  logic [3:0]        key_code_q;
  logic              key_valid_q;
  logic              key_pressed_q;
  logic [3:0]        rows_s;

  keypad_sync #(
    .Width (4)
  ) u_sync (
    .clk    (clk),
    .nreset (nreset),
    .d      (rows),
    .q      (rows_s)
  );

  // Scan/debounce FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q       <= StScan;
      cols_q        <= 4'b1110;
      dwell_q       <= '0;
      cnt_q         <= '0;
      row_q         <= '0;
      key_code_q    <= 4'h0;
      key_valid_q   <= 1'b0;
      key_pressed_q <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rpt_cnt_q     <= '0;
      rpt_first_q   <= 1'b1;
`endif
    end else begin
      key_valid_q <= 1'b0;
      unique case (state_q)
        StScan: begin
          // Rows are only trusted on the last dwell cycle, after the synchronizer settles.
          if (dwell_q == DwellLast) begin
            dwell_q <= '0;
            if (rows_s == 4'hF) begin
              cols_q <= rotate_cols(cols_q);
            end else begin
              row_q   <= lowest_low(rows_s);
              cnt_q   <= '0;
              state_q <= StDebounce;
            end
          end else begin
            dwell_q <= dwell_q + 1'b1;
          end
        end

        StDebounce: begin
          if (!rows_s[row_q]) begin
            if (cnt_q == CntLast) begin
              state_q       <= StHeld;
              key_code_q    <= KeyMap[{row_q, col_index(cols_q)}];
              key_valid_q   <= 1'b1;
              key_pressed_q <= 1'b1;
`ifdef KEYPAD_REPEAT_EN
              rpt_cnt_q     <= '0;
              rpt_first_q   <= 1'b1;
`endif
            end else begin
              cnt_q <= (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
            end
          end else begin
            // Glitch: retry the same column from a fresh dwell.
            state_q <= StScan;
            dwell_q <= '0;
          end
        end

        StHeld: begin
          if (rows_s[row_q]) begin
            state_q <= StRelease;
            cnt_q   <= '0;
`ifdef KEYPAD_REPEAT_EN
            rpt_cnt_q   <= '0;
            rpt_first_q <= 1'b1;
`endif
          end else begin
`ifdef KEYPAD_REPEAT_EN
            if (rpt_cnt_q == (rpt_first_q ? RptDelayLast : RptRateLast)) begin
              key_valid_q <= 1'b1;
              rpt_cnt_q   <= '0;
              rpt_first_q <= 1'b0;
            end else begin
              rpt_cnt_q <= rpt_cnt_q + 1'b1;
            end
`endif
          end
        end

        StRelease: begin
          if (!rows_s[row_q]) begin
            // Release bounce: resume holding without a new pulse.
            state_q <= StHeld;
`ifdef KEYPAD_REPEAT_EN
            rpt_cnt_q   <= '0;
            rpt_first_q <= 1'b1;
`endif
          end else if (cnt_q == CntLast) begin
            state_q       <= StScan;
            cols_q        <= rotate_cols(cols_q);
            dwell_q       <= '0;
            key_pressed_q <= 1'b0;
          end else begin
            cnt_q <= (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
          end
        end

        default: state_q <= StScan;
      endcase
    end
  end

  assign cols       = cols_q;
  assign keyCode    = key_code_q;
  assign keyValid   = key_valid_q;
  assign keyPressed = key_pressed_q;

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Bench for keypad_scan_debounce: switch-matrix model, vector table and pulse scoreboard.
// Define KEYPAD_REPEAT_EN for both bench and RTL to exercise auto-repeat.
module tb_keypad_scan_debounce;

  logic       clk;
  logic       nreset;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] keyCode;
  logic       keyValid;
  logic       keyPressed;

  // Pressed switches, bit index = row*4 + col.
  logic [15:0] keys;
  int          edge_n;
  int          checks;
  int          errors;
  logic        prev_valid;

  typedef struct {
    logic [3:0] code;
    int         lo;
    int         hi;
  } pulse_t;

  pulse_t sb_q[$];

  typedef struct {
    logic [15:0] keys;
    logic [3:0]  cols;
    logic        valid;
    logic        pressed;
  } vec_t;

  vec_t tbl[15];

  keypad_scan_debounce dut (
    .clk        (clk),
    .nreset     (nreset),
    .rows       (rows),
    .cols       (cols),
    .keyCode    (keyCode),
    .keyValid   (keyValid),
    .keyPressed (keyPressed)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edge_n <= edge_n + 1;

  // Passive switch matrix: a pressed key pulls its row low while its column is driven.
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !cols[c]) rows[r] = 1'b0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Pulse monitor, run once per negedge from the stimulus process.
  task automatic monitor();
    pulse_t e;
    if (keyValid) begin
      if (prev_valid) begin
        checks++;
        errors++;
        $display("FAIL back_to_back_pulse: keyValid high two cycles at edge %0d", edge_n);
      end
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got keyCode %0h at edge %0d, none expected",
                 keyCode, edge_n);
      end else begin
        e = sb_q.pop_front();
        check("pulse_code", keyCode, e.code);
        checks++;
        if (edge_n < e.lo || edge_n > e.hi) begin
          errors++;
          $display("FAIL pulse_time: got edge %0d expected %0d..%0d", edge_n, e.lo, e.hi);
        end
      end
    end
    prev_valid = keyValid;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      monitor();
    end
  endtask

  task automatic push(input logic [3:0] code, input int lo, input int hi);
    pulse_t e;
    e.code = code;
    e.lo   = lo;
    e.hi   = hi;
    sb_q.push_back(e);
  endtask

  task automatic expect_drained(input string name);
    check(name, sb_q.size(), 0);
    sb_q.delete();
  endtask

  // Three reset cycles, then release with the given keys already down.
  // Afterwards edge_n+1 is the first edge with reset released.
  task automatic do_reset(input logic [15:0] k);
    nreset = 1'b0;
    keys   = '0;
    tick(3);
    keys   = k;
    nreset = 1'b1;
  endtask

  initial begin
    int r;
    int x;
    int s;
    int y;

    nreset     = 1'b0;
    keys       = '0;
    checks     = 0;
    errors     = 0;
    prev_valid = 1'b0;

    // Idle scan after reset: three cycles per column, wrapping after 0111.
    tbl[0]  = '{16'h0, 4'b1110, 1'b0, 1'b0};
    tbl[1]  = '{16'h0, 4'b1110, 1'b0, 1'b0};
    tbl[2]  = '{16'h0, 4'b1101, 1'b0, 1'b0};
    tbl[3]  = '{16'h0, 4'b1101, 1'b0, 1'b0};
    tbl[4]  = '{16'h0, 4'b1101, 1'b0, 1'b0};
    tbl[5]  = '{16'h0, 4'b1011, 1'b0, 1'b0};
    tbl[6]  = '{16'h0, 4'b1011, 1'b0, 1'b0};
    tbl[7]  = '{16'h0, 4'b1011, 1'b0, 1'b0};
    tbl[8]  = '{16'h0, 4'b0111, 1'b0, 1'b0};
    tbl[9]  = '{16'h0, 4'b0111, 1'b0, 1'b0};
    tbl[10] = '{16'h0, 4'b0111, 1'b0, 1'b0};
    tbl[11] = '{16'h0, 4'b1110, 1'b0, 1'b0};
    tbl[12] = '{16'h0, 4'b1110, 1'b0, 1'b0};
    tbl[13] = '{16'h0, 4'b1110, 1'b0, 1'b0};
    tbl[14] = '{16'h0, 4'b1101, 1'b0, 1'b0};

    // Reset values and idle scanning.
    do_reset(16'h0);
    check("reset_cols", cols, 4'b1110);
    check("reset_code", keyCode, 4'h0);
    check("reset_valid", keyValid, 1'b0);
    check("reset_pressed", keyPressed, 1'b0);
    for (int i = 0; i < 15; i++) begin
      keys = tbl[i].keys;
      tick(1);
      check($sformatf("idle_cols[%0d]", i), cols, tbl[i].cols);
      check($sformatf("idle_valid[%0d]", i), keyValid, tbl[i].valid);
      check($sformatf("idle_pressed[%0d]", i), keyPressed, tbl[i].pressed);
    end
    expect_drained("idle_pending");

    // Clean press of '5' (r1,c1): debounce starts at R+5, pulse at R+25.
    do_reset(16'h0020);
    r = edge_n + 1;
    push(4'h5, r + 25, r + 25);
    while (edge_n < r + 100) begin
      tick(1);
      if (edge_n >= r + 2) check("press5_cols_frozen", cols, 4'b1101);
      if (edge_n == r + 24) check("press5_pressed_before", keyPressed, 1'b0);
      if (edge_n == r + 25) begin
        check("press5_pressed_after", keyPressed, 1'b1);
        check("press5_code", keyCode, 4'h5);
      end
    end
    keys = '0;
    x = edge_n;
    tick(22);
    check("release5_still_pressed", keyPressed, 1'b1);
    tick(1);
    check("release5_dropped", keyPressed, 1'b0);
    check("release5_next_col", cols, 4'b1011);
    tick(20);
    expect_drained("press5_pending");

    // Press bounce, then a stable hold; release with short bounces.
    do_reset(16'h0);
    for (int i = 0; i < 4; i++) begin
      keys = 16'h0020;
      tick(5);
      keys = 16'h0000;
      tick(5);
    end
    s = edge_n;
    keys = 16'h0020;
    push(4'h5, s + 23, s + 34);
    tick(40);
    expect_drained("bounce_pending");
    for (int i = 0; i < 2; i++) begin
      keys = 16'h0000;
      tick(3);
      keys = 16'h0020;
      tick(3);
    end
    keys = 16'h0000;
    x = edge_n;
    tick(22);
    check("bounce_release_still_pressed", keyPressed, 1'b1);
    tick(1);
    check("bounce_release_dropped", keyPressed, 1'b0);
    tick(20);
    expect_drained("bounce_release_pending");

    // Hold 'A' (r0,c3), add '3' (r0,c2): '3' only accepted after 'A' is released.
    do_reset(16'h0008);
    r = edge_n + 1;
    push(4'hA, r + 31, r + 31);
    while (edge_n < r + 40) tick(1);
    check("holdA_code", keyCode, 4'hA);
    keys = 16'h000C;
    tick(50);
    check("holdA_cols_frozen", cols, 4'b0111);
    check("holdA_pressed", keyPressed, 1'b1);
    expect_drained("holdA_pending");
    keys = 16'h0004;
    y = edge_n;
    push(4'h3, y + 52, y + 52);
    tick(60);
    check("key3_code", keyCode, 4'h3);
    expect_drained("key3_pending");

    // Reset in the middle of debouncing '0' (r3,c1), debounce count at 10.
    do_reset(16'h2000);
    r = edge_n + 1;
    while (edge_n < r + 15) tick(1);
    nreset = 1'b0;
    keys   = '0;
    tick(1);
    check("midreset_cols", cols, 4'b1110);
    check("midreset_valid", keyValid, 1'b0);
    check("midreset_pressed", keyPressed, 1'b0);
    tick(1);
    nreset = 1'b1;
    tick(1);
    check("midreset_scan_dwell", cols, 4'b1110);
    tick(2);
    check("midreset_scan_rotate", cols, 4'b1101);
    tick(40);
    expect_drained("midreset_pending");

`ifdef KEYPAD_REPEAT_EN
    // Hold 'D' (r3,c3) for 400 cycles: first pulse at R+31, then delay and rate repeats.
    do_reset(16'h8000);
    r = edge_n + 1;
    push(4'hD, r + 31, r + 31);
    push(4'hD, r + 31 + 240, r + 31 + 240);
    push(4'hD, r + 31 + 288, r + 31 + 288);
    push(4'hD, r + 31 + 336, r + 31 + 336);
    push(4'hD, r + 31 + 384, r + 31 + 384);
    while (edge_n < r + 31 + 400) tick(1);
    keys = '0;
    tick(30);
    expect_drained("repeat_pending");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
